// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and constants for the data-memory responder:
//             RV32I load/store funct3 codes, FSM state type and the captured
//             request record.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    // RV32I load/store size and sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_e;

    // Address is held at full 32-bit width so the record does not depend on
    // the responder's address parameter; only the low bits are meaningful.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dm_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
//  Module   : dmem_lane_align
//  Purpose  : Combinational byte-lane steering for one 32-bit word access.
//             Store side: byte enables plus lane-replicated write data.
//             Load side : selects the addressed bytes of the raw word and
//             sign/zero extends them. Flags misaligned or illegal accesses.
//  Ports    : we_i       - 1 = store, 0 = load
//             funct3_i   - RV32I access size/sign
//             addr_lo_i  - byte offset within the word
//             wdata_i    - lane-0-justified store data
//             rword_i    - raw word read from the store
//             be_o       - per-byte write enables (zero on load or error)
//             wdata_o    - store data replicated across lanes
//             err_o      - misaligned access or illegal funct3
//             rdata_o    - extended load data (zero on store or error)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    logic [31:0] w_shifted;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_err;
    logic [31:0] w_ext;

    // Bring the addressed bytes down to lane 0
    assign w_shifted = rword_i >> {addr_lo_i, 3'b000};

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata_i;
        w_err   = 1'b0;
        w_ext   = 32'd0;
        case (funct3_i)
            F3_B, F3_BU: begin
                w_be    = 4'b0001 << addr_lo_i;
                w_wdata = {4{wdata_i[7:0]}};
                w_ext   = (funct3_i == F3_B) ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                             : {24'd0, w_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                w_err   = addr_lo_i[0];
                w_be    = 4'b0011 << addr_lo_i;
                w_wdata = {2{wdata_i[15:0]}};
                w_ext   = (funct3_i == F3_H) ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                             : {16'd0, w_shifted[15:0]};
            end
            F3_W: begin
                w_err = (addr_lo_i != 2'b00);
                w_be  = 4'b1111;
                w_ext = rword_i;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
        // Unsigned variants exist only for loads
        if (we_i && funct3_i[2]) begin
            w_err = 1'b1;
        end
    end

    assign err_o   = w_err;
    assign be_o    = (we_i && !w_err) ? w_be : 4'b0000;
    assign wdata_o = w_wdata;
    assign rdata_o = (!we_i && !w_err) ? w_ext : 32'd0;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory-side responder for MEM-stage loads/stores. Accepts one
//             request in IDLE, waits WAIT_CYCLES, then pulses resp_valid for
//             one cycle with the load result / error flag.
//  Ports    : clk, reset (async, active-low)
//             req_valid/req_ready handshake; req_we, req_addr, req_wdata,
//             req_funct3 request fields
//             resp_valid one-cycle completion pulse; resp_rdata, resp_err
//             result, held until the next completion
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int         c_DEPTH     = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] c_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dm_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dm_req_t     req_q, req_d;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [c_DEPTH];

    dm_req_t                 w_live;
    dm_req_t                 w_cur;
    logic [DM_ADDRESS-3:0]   w_idx;
    logic [31:0]             w_rword;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic                    w_err;
    logic [31:0]             w_ldata;
    logic                    w_commit;
    logic                    w_unused_addr;

    assign w_live = '{we: req_we, addr: 32'(req_addr), wdata: req_wdata, funct3: req_funct3};

    // With no wait states the commit edge is the accept edge itself, so the
    // request has not reached the holding register yet: use the live inputs.
    assign w_cur         = (state_q == DM_IDLE) ? w_live : req_q;
    assign w_idx         = w_cur.addr[DM_ADDRESS-1:2];
    assign w_rword       = mem[w_idx];
    assign w_unused_addr = ^w_cur.addr[31:DM_ADDRESS];

    dmem_lane_align u_align (
        .we_i      (w_cur.we),
        .funct3_i  (w_cur.funct3),
        .addr_lo_i (w_cur.addr[1:0]),
        .wdata_i   (w_cur.wdata),
        .rword_i   (w_rword),
        .be_o      (w_be),
        .wdata_o   (w_wdata),
        .err_o     (w_err),
        .rdata_o   (w_ldata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        w_commit = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (req_valid) begin
                    req_d = w_live;
                    if (WAIT_CYCLES > 0) begin
                        state_d = DM_WAIT;
                    end else begin
                        state_d  = DM_RESP;
                        w_commit = 1'b1;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt_q == c_WAIT_LAST) begin
                    state_d  = DM_RESP;
                    cnt_d    = 4'd0;
                    w_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DM_RESP: begin
                state_d = DM_IDLE;
            end
            default: begin
                state_d = DM_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DM_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            if (w_commit) begin
                rdata_q <= w_ldata;
                err_q   <= w_err;
            end
        end
    end

    // Store array is not reset; a write is suppressed while reset is low.
    always_ff @(posedge clk) begin
        if (w_commit && reset) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == DM_IDLE);
    assign resp_valid = (state_q == DM_RESP);
    assign resp_rdata = DATA_W'(rdata_q);
    assign resp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder. Instance 0 uses two wait
//             states, instance 1 uses none. Expected results come from a
//             byte-array model of the store.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [8:0]  req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  req_funct3 [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int          lat [2] = '{2, 0};
    logic [7:0]  mm  [2][512];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I semantics on a flat byte array
    task automatic model(input int s, input logic we, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f,
                         output logic [31:0] rd, output logic er);
        int          size;
        logic [31:0] v;
        size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        er = (f == 3'b011) || (f == 3'b110) || (f == 3'b111) || (we && f[2]) ||
             (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < size; i++) mm[s][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = mm[s][int'(a) + i];
                if (!f[2] && size < 4 && v[8*size-1])
                    for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
                rd = v;
            end
        end
    endtask

    task automatic do_req(input int s, input logic we, input logic [8:0] a,
                          input logic [31:0] wd, input logic [2:0] f,
                          output logic [31:0] got, output logic got_err);
        logic [31:0] er_d;
        logic        er_e;
        int          k;
        model(s, we, a, wd, f, er_d, er_e);
        @(negedge clk);
        req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = a;
        req_wdata[s] = wd;   req_funct3[s] = f;
        chk("req_ready_idle", {31'd0, req_ready[s]}, 32'd1);
        @(posedge clk);
        #1 req_valid[s] = 1'b0;
        k = 0;
        @(negedge clk);
        while (!resp_valid[s] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, lat[s]);
        got     = resp_rdata[s];
        got_err = resp_err[s];
        chk("rdata", got, er_d);
        chk("err", {31'd0, got_err}, {31'd0, er_e});
        @(negedge clk);
        chk("resp_pulse", {31'd0, resp_valid[s]}, 32'd0);
        chk("rdata_hold", resp_rdata[s], er_d);
    endtask

    task automatic hold_test(input int s, input int n);
        logic [32:0] q[$];
        logic [32:0] e;
        logic [31:0] rd;
        logic        er;
        logic        take;
        int          accepts, resps, last, cyc;
        accepts = 0; resps = 0; last = 0; cyc = 0;
        @(negedge clk);
        req_valid[s] = 1'b1; req_we[s] = 1'b1; req_addr[s] = 9'h1FC;
        req_wdata[s] = $urandom; req_funct3[s] = 3'b010;
        while (resps < n && cyc < 400) begin
            if (resp_valid[s]) begin
                resps++;
                chk("hold_extra_resp", resps <= accepts, 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("hold_rdata", resp_rdata[s], e[31:0]);
                    chk("hold_err", {31'd0, resp_err[s]}, {31'd0, e[32]});
                end
            end
            take = req_ready[s] && req_valid[s];
            if (take) begin
                if (accepts > 0) chk("hold_spacing", cyc - last, lat[s] + 2);
                last = cyc;
                model(s, req_we[s], req_addr[s], req_wdata[s], req_funct3[s], rd, er);
                q.push_back({er, rd});
                accepts++;
            end
            @(posedge clk);
            #1;
            if (take) begin
                if (accepts == n) req_valid[s] = 1'b0;
                else begin
                    req_we[s]    = ~req_we[s];
                    req_wdata[s] = $urandom;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("hold_resps", resps, n);
        chk("hold_accepts", accepts, n);
        chk("hold_pulse_end", {31'd0, resp_valid[s]}, 32'd0);
    endtask

    initial begin : stim
        logic [31:0] g;
        logic        ge;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
            req_wdata[s] = '0;   req_funct3[s] = '0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", {31'd0, req_ready[s]}, 32'd1);
            chk("rst_valid", {31'd0, resp_valid[s]}, 32'd0);
            chk("rst_rdata", resp_rdata[s], 32'd0);
            chk("rst_err", {31'd0, resp_err[s]}, 32'd0);
        end
        reset = 1'b1;

        // Fill both stores so every later load has defined contents
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 128; w++) do_req(s, 1'b1, 9'(w * 4), $urandom, 3'b010, g, ge);

        // Directed cases on the two-wait-state instance
        do_req(0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, g, ge);
        do_req(0, 1'b0, 9'h010, 32'h0, 3'b010, g, ge);
        chk("t1_lw", g, 32'hDEADBEEF);
        do_req(0, 1'b1, 9'h013, 32'h000000A5, 3'b000, g, ge);
        do_req(0, 1'b0, 9'h010, 32'h0, 3'b010, g, ge);
        chk("t2_lw", g, 32'hA5ADBEEF);
        do_req(0, 1'b0, 9'h013, 32'h0, 3'b000, g, ge);
        chk("t2_lb", g, 32'hFFFFFFA5);
        do_req(0, 1'b0, 9'h013, 32'h0, 3'b100, g, ge);
        chk("t2_lbu", g, 32'h000000A5);
        do_req(0, 1'b1, 9'h022, 32'h00008001, 3'b001, g, ge);
        do_req(0, 1'b0, 9'h022, 32'h0, 3'b001, g, ge);
        chk("t3_lh", g, 32'hFFFF8001);
        do_req(0, 1'b0, 9'h022, 32'h0, 3'b101, g, ge);
        chk("t3_lhu", g, 32'h00008001);
        do_req(0, 1'b0, 9'h021, 32'h0, 3'b001, g, ge);
        chk("t3_lh_mis_err", {31'd0, ge}, 32'd1);
        chk("t3_lh_mis_rdata", g, 32'd0);
        do_req(0, 1'b0, 9'h020, 32'h0, 3'b010, g, ge);
        chk("t3_unchanged", g[31:16], 32'h00008001);
        do_req(0, 1'b1, 9'h031, 32'h11223344, 3'b010, g, ge);
        chk("t4_sw_mis_err", {31'd0, ge}, 32'd1);
        do_req(0, 1'b0, 9'h030, 32'h0, 3'b010, g, ge);
        do_req(0, 1'b0, 9'h030, 32'h0, 3'b011, g, ge);
        chk("t4_f3_011_err", {31'd0, ge}, 32'd1);

        // Reset between accept and commit discards the store
        do_req(0, 1'b1, 9'h040, 32'hCAFEF00D, 3'b010, g, ge);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 9'h040;
        req_wdata[0] = 32'h12345678; req_funct3[0] = 3'b010;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("t5_valid", {31'd0, resp_valid[0]}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_req(0, 1'b0, 9'h040, 32'h0, 3'b010, g, ge);
        chk("t5_preserved", g, 32'hCAFEF00D);

        // Randomised traffic on both instances
        for (int n = 0; n < 60; n++) begin
            for (int s = 0; s < 2; s++)
                do_req(s, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom,
                       3'($urandom_range(0, 7)), g, ge);
        end

        // Continuous request stream at the top word
        hold_test(0, 8);
        hold_test(1, 8);
        do_req(1, 1'b0, 9'h1FE, 32'h0, 3'b101, g, ge);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
